mtm_alu_serializer: RTL and testbench

Output side of the mtm_Alu serial protocol. Accepts one ALU result word with its flags, or one error indication, through a valid/ready handshake. Frames it into 11-bit serial packets and shifts them out on `sout`, one bit per clock. Sits between the ALU core and the chip output pin; it is the counterpart of the input deserializer that decodes `sin`.

---
 rtl/mtm_alu_serializer_if.sv | 11 +
 rtl/mtm_alu_serializer.sv | 80 ++++++++
 tb/tb_mtm_alu_serializer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mtm_alu_serializer_if.sv
// mtm_alu_serializer_if: valid/ready handshake carrying an ALU result or error indication.
interface mtm_alu_serializer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] res_data;
    logic [3:0]  res_flags;
    logic        err;
    logic [2:0]  err_flags;
    modport master (output in_valid, res_data, res_flags, err, err_flags, input in_ready);
    modport slave  (input in_valid, res_data, res_flags, err, err_flags, output in_ready);
endinterface

// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer: frames an ALU result or error into 11-bit serial packets on sout.
// Define MTM_ALU_SER_PKT_GAP_EN to insert one idle bit after each non-final packet.
module mtm_alu_serializer (
    input  logic                       clk,
    input  logic                       rst_n,
    mtm_alu_serializer_if.slave        bus,
    output logic                       sout
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t      state, state_nxt;
    logic [31:0] data_q;
    logic [3:0]  flags_q;
    logic        err_q;
    logic [2:0]  eflags_q;
    logic [2:0]  pkt, pkt_nxt;
    logic [3:0]  bit_cnt, bit_nxt, pay_idx;
    logic [36:0] msg;
    logic [2:0]  crc;
    logic [7:0]  ctl_payload, payload;
    logic        ctl, last_pkt, pkt_end, frame_end, accept, tx_bit, sout_nxt;

    assign bus.in_ready = state == IDLE;
    assign accept       = bus.in_valid && state == IDLE;

    // CRC x^3+x+1 over {data, 0, flags}, MSB first, init 0
    always_comb begin
        crc = 3'b000;
        msg = {data_q, 1'b0, flags_q};
        for (int i = 36; i >= 0; i--)
            crc = {crc[1:0], 1'b0} ^ ((crc[2] ^ msg[i]) ? 3'b011 : 3'b000);
    end

    assign ctl_payload = err_q ? {1'b1, eflags_q, eflags_q, ^{1'b1, eflags_q, eflags_q}}
                               : {1'b0, flags_q, crc};
    assign last_pkt    = err_q || pkt == 3'd4;
    assign ctl         = last_pkt;
    assign payload     = ctl ? ctl_payload : data_q[{~pkt[1:0], 3'b000} +: 8];
    assign pay_idx     = 4'd9 - bit_cnt;
    assign tx_bit      = bit_cnt == 4'd0 ? 1'b0 :
                         bit_cnt == 4'd1 ? ctl :
                         bit_cnt <= 4'd9 ? payload[pay_idx[2:0]] : 1'b1;

`ifdef MTM_ALU_SER_PKT_GAP_EN
    assign pkt_end = bit_cnt == (last_pkt ? 4'd10 : 4'd11);
`else
    assign pkt_end = bit_cnt == 4'd10;
`endif
    assign frame_end = pkt_end && last_pkt;

    always_comb begin
        state_nxt = state == IDLE ? (bus.in_valid ? SEND : IDLE) : (frame_end ? IDLE : SEND);
        bit_nxt   = (state == IDLE || pkt_end) ? 4'd0 : bit_cnt + 4'd1;
        pkt_nxt   = state == IDLE ? 3'd0 : (pkt_end ? pkt + 3'd1 : pkt);
        sout_nxt  = state == SEND ? tx_bit : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pkt      <= '0;
            bit_cnt  <= '0;
            sout     <= 1'b1;
            data_q   <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            eflags_q <= '0;
        end else begin
            state   <= state_nxt;
            pkt     <= pkt_nxt;
            bit_cnt <= bit_nxt;
            sout    <= sout_nxt;
            if (accept) begin
                data_q   <= bus.res_data;
                flags_q  <= bus.res_flags;
                err_q    <= bus.err;
                eflags_q <= bus.err_flags;
            end
        end
    end
endmodule

// File: tb/tb_mtm_alu_serializer.sv
// tb_mtm_alu_serializer: scoreboard bench; a bench deserializer checks sout against a reference frame model.
module tb_mtm_alu_serializer;
`ifdef MTM_ALU_SER_PKT_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sout;
    mtm_alu_serializer_if bus();
    mtm_alu_serializer dut (.clk(clk), .rst_n(rst_n), .bus(bus), .sout(sout));
    always #5 clk = ~clk;

    typedef struct {logic [58:0] bits; int len;} frame_t;
    frame_t exp_q[$];
    int     len_q[$];
    int     total = 0;
    int     bad = 0;
    bit     mon_en = 1'b0;
    frame_t fb;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic fail_now(string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // reference CRC as remainder of M(x)*x^3 mod x^3+x+1 by long division
    function automatic logic [2:0] crc_ref(logic [31:0] d, logic [3:0] fl);
        logic [39:0] v = {d, 1'b0, fl, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (v[i]) v = v ^ (40'b1011 << (i - 3));
        return v[2:0];
    endfunction

    task automatic frame_start();
        fb.bits = '1;
        fb.len  = 0;
    endtask

    task automatic add_pkt(logic t, logic [7:0] p, bit last);
        fb.bits[fb.len]     = 1'b0;
        fb.bits[fb.len + 1] = t;
        for (int i = 0; i < 8; i++) fb.bits[fb.len + 2 + i] = p[7 - i];
        fb.bits[fb.len + 10] = 1'b1;
        fb.len += 11;
        if (GAP && !last) begin
            fb.bits[fb.len] = 1'b1;
            fb.len++;
        end
    endtask

    task automatic model(logic [31:0] d, logic [3:0] fl, logic e, logic [2:0] ef);
        logic [7:0] ep;
        frame_start();
        if (e) begin
            ep = {1'b1, ef, ef, 1'b0};
            ep[0] = ($countones(ep) % 2) != 0;
            add_pkt(1'b1, ep, 1'b1);
        end else begin
            for (int i = 0; i < 4; i++) add_pkt(1'b0, 8'((d >> (24 - 8 * i)) & 32'hFF), 1'b0);
            add_pkt(1'b1, {1'b0, fl, crc_ref(d, fl)}, 1'b1);
        end
    endtask

    task automatic send(logic [31:0] d, logic [3:0] fl, logic e, logic [2:0] ef, frame_t f, bit hold);
        int w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) fail_now("ready_timeout");
        bus.in_valid  = 1'b1;
        bus.res_data  = d;
        bus.res_flags = fl;
        bus.err       = e;
        bus.err_flags = ef;
        @(posedge clk);
        exp_q.push_back(f);
        len_q.push_back(f.len);
        #1;
        if (hold) begin
            bus.res_data  = $urandom;
            bus.res_flags = 4'($urandom);
            bus.err       = 1'($urandom);
            bus.err_flags = 3'($urandom);
        end else bus.in_valid = 1'b0;
    endtask

    // bench deserializer: start bit triggers collection of the expected frame length
    initial begin
        frame_t f;
        logic [58:0] got;
        int idle = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) idle = 0;
            else if (sout === 1'b0) begin
                idle = 0;
                if (exp_q.size() == 0) fail_now("unexpected_start");
                else begin
                    f = exp_q.pop_front();
                    got = '1;
                    got[0] = sout;
                    for (int k = 1; k < f.len; k++) begin
                        @(negedge clk);
                        got[k] = sout;
                    end
                    check("frame", 64'(got), 64'(f.bits));
                    @(negedge clk);
                    check("idle_gap", 64'(sout), 64'(1));
                end
            end else if (exp_q.size() > 0) begin
                idle++;
                if (idle > 200) begin
                    fail_now("start_timeout");
                    void'(exp_q.pop_front());
                    idle = 0;
                end
            end else idle = 0;
        end
    end

    initial begin
        int run = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) run = 0;
            else if (!bus.in_ready) run++;
            else if (run > 0) begin
                if (len_q.size() == 0) fail_now("unexpected_busy");
                else check("ready_low", 64'(run), 64'(len_q.pop_front()));
                run = 0;
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  fl;
        logic        e;
        logic [2:0]  ef;
        int          w;
        bus.in_valid  = 1'b0;
        bus.res_data  = '0;
        bus.res_flags = '0;
        bus.err       = 1'b0;
        bus.err_flags = '0;
        repeat (2) @(negedge clk);
        check("rst_sout", 64'(sout), 64'(1));
        check("rst_ready", 64'(bus.in_ready), 64'(1));
        rst_n = 1'b1;
        // asynchronous reset in the middle of a frame
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.res_data = 32'h0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sout", 64'(sout), 64'(1));
        check("midrst_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        frame_start();
        for (int i = 0; i < 4; i++) add_pkt(1'b0, 8'h00, 1'b0);
        add_pkt(1'b1, 8'h16, 1'b1);
        send(32'h0, 4'b0010, 1'b0, 3'b000, fb, 1'b0);
        frame_start();
        for (int i = 0; i < 3; i++) add_pkt(1'b0, 8'h00, 1'b0);
        add_pkt(1'b0, 8'h01, 1'b0);
        add_pkt(1'b1, 8'h02, 1'b1);
        send(32'h1, 4'b0000, 1'b0, 3'b000, fb, 1'b0);
        frame_start();
        add_pkt(1'b1, 8'hC9, 1'b1);
        send(32'hDEADBEEF, 4'hF, 1'b1, 3'b100, fb, 1'b0);
        frame_start();
        add_pkt(1'b1, 8'hA5, 1'b1);
        send(32'h12345678, 4'h3, 1'b1, 3'b010, fb, 1'b0);
        frame_start();
        add_pkt(1'b1, 8'h81, 1'b1);
        send(32'hFFFFFFFF, 4'h0, 1'b1, 3'b000, fb, 1'b0);
        // back-to-back with in_valid held and inputs scrambled during SEND
        for (int i = 0; i < 6; i++) begin
            d = $urandom; fl = 4'($urandom); e = (i == 3); ef = 3'($urandom);
            model(d, fl, e, ef);
            send(d, fl, e, ef, fb, 1'b1);
        end
        @(negedge clk);
        while (!bus.in_ready) @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            d = $urandom; fl = 4'($urandom); e = ($urandom_range(0, 9) == 0); ef = 3'($urandom);
            model(d, fl, e, ef);
            send(d, fl, e, ef, fb, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                while (!bus.in_ready) @(negedge clk);
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        while (!bus.in_ready) @(negedge clk);
        bus.in_valid = 1'b0;
        w = 0;
        while ((exp_q.size() > 0 || len_q.size() > 0) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
        if (exp_q.size() > 0 || len_q.size() > 0) fail_now("drain_timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
